// File: rtl/pe_bus_arbiter.sv
// Round-robin bus arbiter for NUM_PE processing elements with a one-cycle dead slot between tenures.
// Latency: request to grant is one clock; a dropped request releases the bus at the next edge.
// Backpressure: a grant holds until its owner drops its request (bounded by the ARB_WATCHDOG_EN hold watchdog).
module pe_bus_arbiter #(
  parameter int NUM_PE   = 4,
  parameter int MAX_HOLD = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_PE-1:0] bus_request,
  output logic [NUM_PE-1:0] grant,
  output logic [2:0]        grant_id,
  output logic              bus_busy,
  output logic              timeout_err,
  output logic [2:0]        timeout_id
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  // Reject parameter values the encodings cannot represent.
  if (NUM_PE < 2 || NUM_PE > 8) begin : g_bad_num_pe
    $error("pe_bus_arbiter: NUM_PE must be 2..8");
  end
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("pe_bus_arbiter: MAX_HOLD must be 2..255");
  end

  state_t            state, state_nxt;
  logic [NUM_PE-1:0] grant_nxt;
  logic [2:0]        grant_id_nxt;
  logic [2:0]        last_id, last_id_nxt;
  logic              win_vld;
  logic [2:0]        win_id;
  logic [2:0]        cand;
  logic              req_cur;

`ifdef ARB_WATCHDOG_EN
  logic [7:0] hold_cnt, hold_cnt_nxt;
  logic       timeout_err_nxt;
  logic [2:0] timeout_id_nxt;
`endif

  // Current owner still wants the bus (grant is one-hot, so this selects its request bit).
  assign req_cur  = |(bus_request & grant);
  assign bus_busy = |grant;

  // Round-robin search upward from last_id+1; walking offsets downward lets the nearest requester win.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    cand    = '0;
    for (int k = NUM_PE; k >= 1; k--) begin
      cand = 3'((int'(last_id) + k) % NUM_PE);
      if ((bus_request & (NUM_PE'(1) << cand)) != '0) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  // Next-state and next-output logic for the IDLE/GRANT/RELEASE tenure machine.
  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    grant_id_nxt = grant_id;
    last_id_nxt  = last_id;
`ifdef ARB_WATCHDOG_EN
    hold_cnt_nxt    = hold_cnt;
    timeout_err_nxt = 1'b0;
    timeout_id_nxt  = timeout_id;
`endif
    case (state)
      IDLE, RELEASE: begin
        if (win_vld) begin
          state_nxt    = GRANT;
          grant_nxt    = NUM_PE'(1) << win_id;
          grant_id_nxt = win_id;
          last_id_nxt  = win_id;
`ifdef ARB_WATCHDOG_EN
          hold_cnt_nxt = 8'd1;
`endif
        end else begin
          state_nxt    = IDLE;
          grant_nxt    = '0;
          grant_id_nxt = '0;
        end
      end
      GRANT: begin
        if (!req_cur) begin
          // Owner let go: free the bus and insert the dead cycle. Other requesters never preempt.
          state_nxt    = RELEASE;
          grant_nxt    = '0;
          grant_id_nxt = '0;
`ifdef ARB_WATCHDOG_EN
        end else if (hold_cnt == 8'(MAX_HOLD)) begin
          // Tenure overran: revoke without masking the owner; it re-competes at lowest priority.
          state_nxt       = RELEASE;
          grant_nxt       = '0;
          grant_id_nxt    = '0;
          timeout_err_nxt = 1'b1;
          timeout_id_nxt  = grant_id;
        end else begin
          hold_cnt_nxt = (hold_cnt == 8'd255) ? hold_cnt : hold_cnt + 8'd1;
`endif
        end
      end
      default: begin
        state_nxt    = IDLE;
        grant_nxt    = '0;
        grant_id_nxt = '0;
      end
    endcase
  end

  // State register; last_id resets to NUM_PE-1 so PE 0 wins first after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      last_id  <= 3'(NUM_PE - 1);
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      grant_id <= grant_id_nxt;
      last_id  <= last_id_nxt;
    end
  end

`ifdef ARB_WATCHDOG_EN
  // Hold counter and timeout reporting registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_cnt    <= '0;
      timeout_err <= 1'b0;
      timeout_id  <= '0;
    end else begin
      hold_cnt    <= hold_cnt_nxt;
      timeout_err <= timeout_err_nxt;
      timeout_id  <= timeout_id_nxt;
    end
  end
`else
  assign timeout_err = 1'b0;
  assign timeout_id  = 3'd0;
`endif

endmodule

// File: tb/tb_pe_bus_arbiter.sv
// Directed bench for pe_bus_arbiter: expected grant/timeout values queued per step, compared after each edge.
// Latency: each step drives inputs, waits one rising edge, then checks the registered outputs.
// Backpressure: none; the bench drives requests directly and a free-running monitor checks one-hot grant.
module tb_pe_bus_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] bus_request;
  logic [3:0] grant;
  logic [2:0] grant_id;
  logic       bus_busy;
  logic       timeout_err;
  logic [2:0] timeout_id;

  typedef struct packed {
    logic [3:0] g;
    logic       terr;
    logic [2:0] tid;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic       mon_en = 1'b0;
  logic [3:0] prev_g = 4'b0000;
  logic [2:0] exp_tid = 3'd0;

  pe_bus_arbiter #(.NUM_PE(4), .MAX_HOLD(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus_request (bus_request),
    .grant       (grant),
    .grant_id    (grant_id),
    .bus_busy    (bus_busy),
    .timeout_err (timeout_err),
    .timeout_id  (timeout_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] enc(input logic [3:0] g);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 3'(i);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, queue expectation, clock, pop and compare.
  task automatic step(input logic rst, input logic [3:0] req, input logic [3:0] eg,
                      input logic eterr, input string tag);
    exp_t e;
    reset       = rst;
    bus_request = req;
    if (!rst) exp_tid = 3'd0;
    else if (eterr) exp_tid = enc(prev_g);
    e.g    = eg;
    e.terr = eterr;
    e.tid  = exp_tid;
    sb.push_back(e);
    prev_g = eg;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, " grant"},    {4'b0, grant},         {4'b0, e.g});
    chk({tag, " busy"},     {7'b0, bus_busy},      {7'b0, (e.g != 4'b0)});
    chk({tag, " grant_id"}, {5'b0, grant_id},      {5'b0, enc(e.g)});
    chk({tag, " t_err"},    {7'b0, timeout_err},   {7'b0, e.terr});
    chk({tag, " t_id"},     {5'b0, timeout_id},    {5'b0, e.tid});
  endtask

  // Invariants on every cycle: grant one-hot or zero, bus_busy tracks OR(grant).
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      assert ($onehot0(grant)) else begin
        errors++;
        $error("FAIL onehot: got %b expected at most one bit", grant);
      end
      checks++;
      assert (bus_busy === |grant) else begin
        errors++;
        $error("FAIL busy_or: got %b expected %b", bus_busy, |grant);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, checks %0d", checks);
    $fatal(1, "bench time limit reached");
  end

  initial begin
    logic [3:0] oh;
    reset       = 1'b0;
    bus_request = 4'b0000;

    // Reset state
    step(1'b0, 4'b0000, 4'b0000, 1'b0, "reset0");
    mon_en = 1'b1;
    step(1'b0, 4'b1111, 4'b0000, 1'b0, "reset_req");
    step(1'b1, 4'b0000, 4'b0000, 1'b0, "idle");

    // Single request: grant one cycle after request, dead cycle, back to IDLE
    step(1'b1, 4'b0100, 4'b0100, 1'b0, "single_g");
    step(1'b1, 4'b0100, 4'b0100, 1'b0, "single_h1");
    step(1'b1, 4'b0100, 4'b0100, 1'b0, "single_h2");
    step(1'b1, 4'b0000, 4'b0000, 1'b0, "single_rel");
    step(1'b1, 4'b0000, 4'b0000, 1'b0, "single_idle");

    // Round-robin: reset so PE 0 leads, each grantee drops for one cycle after 3 grant cycles
    step(1'b0, 4'b0000, 4'b0000, 1'b0, "rr_reset");
    for (int p = 0; p < 4; p++) begin
      oh = 4'b0001 << p;
      step(1'b1, 4'b1111, oh, 1'b0, "rr_grant");
      step(1'b1, 4'b1111, oh, 1'b0, "rr_hold1");
      step(1'b1, 4'b1111, oh, 1'b0, "rr_hold2");
      step(1'b1, 4'b1111 & ~oh, 4'b0000, 1'b0, "rr_dead");
    end
    step(1'b1, 4'b1111, 4'b0001, 1'b0, "rr_wrap0");
    step(1'b1, 4'b0000, 4'b0000, 1'b0, "rr_rel");
    step(1'b1, 4'b0000, 4'b0000, 1'b0, "rr_idle");

    // No preemption: PE 1 owns the bus while PE 0 waits
    step(1'b1, 4'b0010, 4'b0010, 1'b0, "np_g1");
    step(1'b1, 4'b0011, 4'b0010, 1'b0, "np_hold1");
    step(1'b1, 4'b0011, 4'b0010, 1'b0, "np_hold2");
    step(1'b1, 4'b0001, 4'b0000, 1'b0, "np_dead");
    step(1'b1, 4'b0001, 4'b0001, 1'b0, "np_g0");
    step(1'b1, 4'b0000, 4'b0000, 1'b0, "np_rel");
    step(1'b1, 4'b0000, 4'b0000, 1'b0, "np_idle");

    // Reset mid-tenure: PE 2 granted, reset drops it, then PE 0 wins first
    step(1'b1, 4'b0100, 4'b0100, 1'b0, "rm_g2");
    step(1'b1, 4'b0100, 4'b0100, 1'b0, "rm_hold");
    step(1'b0, 4'b0100, 4'b0000, 1'b0, "rm_reset");
    step(1'b1, 4'b0101, 4'b0001, 1'b0, "rm_g0");
    step(1'b1, 4'b0101, 4'b0001, 1'b0, "rm_hold0");
    step(1'b1, 4'b0100, 4'b0000, 1'b0, "rm_dead");
    step(1'b1, 4'b0101, 4'b0100, 1'b0, "rm_g2b");
    step(1'b1, 4'b0000, 4'b0000, 1'b0, "rm_rel");
    step(1'b1, 4'b0000, 4'b0000, 1'b0, "rm_idle");

    // Wrap-around search: last winner 2, requests 0 and 1 -> 3 absent, wraps to 0
    step(1'b1, 4'b0011, 4'b0001, 1'b0, "wrap_g0");
    step(1'b1, 4'b0010, 4'b0000, 1'b0, "wrap_dead");
    step(1'b1, 4'b0010, 4'b0010, 1'b0, "wrap_g1");
    step(1'b1, 4'b0000, 4'b0000, 1'b0, "wrap_rel");
    step(1'b1, 4'b0000, 4'b0000, 1'b0, "wrap_idle");

`ifdef ARB_WATCHDOG_EN
    // Watchdog: PE 3 revoked after 4 grant cycles, PE 0 granted next
    step(1'b1, 4'b1000, 4'b1000, 1'b0, "wd_g3");
    step(1'b1, 4'b1001, 4'b1000, 1'b0, "wd_hold2");
    step(1'b1, 4'b1001, 4'b1000, 1'b0, "wd_hold3");
    step(1'b1, 4'b1001, 4'b1000, 1'b0, "wd_hold4");
    step(1'b1, 4'b1001, 4'b0000, 1'b1, "wd_revoke");
    step(1'b1, 4'b1001, 4'b0001, 1'b0, "wd_g0");
    step(1'b1, 4'b1000, 4'b0000, 1'b0, "wd_rel");
    step(1'b1, 4'b0000, 4'b0000, 1'b0, "wd_idle");
`else
    // Unbounded tenure: PE 3 keeps the bus well past MAX_HOLD with no timeout
    step(1'b1, 4'b1000, 4'b1000, 1'b0, "nowd_g3");
    for (int i = 0; i < 8; i++) step(1'b1, 4'b1001, 4'b1000, 1'b0, "nowd_hold");
    step(1'b1, 4'b0001, 4'b0000, 1'b0, "nowd_dead");
    step(1'b1, 4'b0001, 4'b0001, 1'b0, "nowd_g0");
    step(1'b1, 4'b0000, 4'b0000, 1'b0, "nowd_rel");
`endif

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
